// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Imported by the receive-side controller, its FIFO and the bus interface.
package uart_pkg;

  localparam int DBIT_DEFAULT       = 8;
  localparam int SB_TICK_DEFAULT    = 16;
  localparam int DVSR_115200_100MHZ = 53;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus-side view of the UART receive controller: pop/clear requests plus FIFO status.
// Pop handshake: rx_empty low acts as valid and rx_data is the head; rd_uart acts as ready, and a byte is consumed only on an edge where both are true.
interface uart_rx_ctrl_if #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
);

  logic              rd_uart;
  logic              clr_ovr;
  logic [DBIT-1:0]   rx_data;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_overrun;
  logic [FIFO_W:0]   rx_count;

  modport master (
    output rd_uart, clr_ovr,
    input  rx_data, rx_empty, rx_full, rx_overrun, rx_count
  );

  modport slave (
    input  rd_uart, clr_ovr,
    output rx_data, rx_empty, rx_full, rx_overrun, rx_count
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: first-word fall-through, separate occupancy count, cleared storage on reset.
// Reports a write attempt that had to be dropped so the controller can raise overrun.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              rd,
  output logic [DBIT-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic [FIFO_W:0]   count,
  output logic              ovr_try
);

  localparam int              DEPTH    = fifo_depth(FIFO_W);
  localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W + 1)'(DEPTH);

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [DBIT-1:0]   mem_d [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W:0]   count_q, count_d;
  logic              wr_en, rd_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rd_en   = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_en   = wr && (!full || rd_en);
  assign ovr_try = wr && full && !rd;
  assign r_data  = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = w_data;
      wr_ptr_d        = wr_ptr_q + FIFO_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + FIFO_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (FIFO_W + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: 16x baud tick generator, receive FIFO and sticky overrun flag.
// The receiver itself lives next to this block and is driven by s_tick.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEFAULT,
  parameter int FIFO_W = 2,
  parameter int DVSR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout,
  uart_rx_ctrl_if.slave     bus
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              ovr_try;
  logic [DBIT-1:0]   fifo_data;
  logic              fifo_empty, fifo_full;
  logic [FIFO_W:0]   fifo_count;

  // Compare with >= so a divisor lowered below the running count wraps at once.
  assign s_tick = (cnt_q >= dvsr);

  always_comb begin
    cnt_d = s_tick ? '0 : cnt_q + DVSR_W'(1);
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_try) begin
      ovr_d = 1'b1;
    end else if (bus.clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .DBIT   (DBIT),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (rx_done_tick),
    .w_data  (rx_dout),
    .rd      (bus.rd_uart),
    .r_data  (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count),
    .ovr_try (ovr_try)
  );

  assign bus.rx_data    = fifo_data;
  assign bus.rx_empty   = fifo_empty;
  assign bus.rx_full    = fifo_full;
  assign bus.rx_count   = fifo_count;
  assign bus.rx_overrun = ovr_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART receiver datapath, which consumes s_tick and produces rx_done_tick and dout.
- Generates the 16x-oversampling baud tick from a programmable divisor.
- Captures each completed byte into a small FIFO and exposes a pop-style read interface plus status flags to the bus-side register wrapper.
- Sits between the receiver and the MMIO slot; the receiver is instantiated alongside it, not inside it.

Parameters:
- DBIT, 8, data bits per frame; must match the receiver's DBIT.
- FIFO_W, 2, FIFO address width; depth = 2**FIFO_W entries.
- DVSR_W, 11, width of the baud divisor.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dvsr  in  DVSR_W  baud divisor; tick period = dvsr+1 clk cycles.
- s_tick  out  1  oversampling tick to the receiver.
- rx_done_tick  in  1  one-cycle pulse from the receiver: byte complete.
- rx_dout  in  DBIT  received byte; valid in the rx_done_tick cycle.
- rd_uart  in  1  pop request from the bus side.
- clr_ovr  in  1  clears the overrun flag.
- rx_data  out  DBIT  FIFO head; first-word fall-through.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_overrun  out  1  sticky flag: a byte was dropped.
- rx_count  out  FIFO_W+1  current occupancy, 0..2**FIFO_W.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Tick counter = 0; FIFO pointers = 0; overrun = 0.
  - Outputs: rx_empty=1, rx_full=0, rx_count=0, rx_overrun=0, rx_data=0 (storage cleared).
- Baud generator:
  - DVSR_W-bit counter cnt; s_tick = (cnt >= dvsr), combinational.
  - On each clk: if cnt >= dvsr then cnt <= 0, else cnt <= cnt+1.
  - dvsr=0 gives s_tick high every cycle, including the first cycle after reset.
  - dvsr lowered below cnt mid-count: tick fires on the next cycle and cnt wraps. There is no 2**DVSR_W-cycle stall.
  - dvsr raised: the current count simply continues toward the new value.
- FIFO write: on rx_done_tick, if not full, store rx_dout at wr_ptr and increment wr_ptr (wraps mod depth) and count.
- Overrun: rx_done_tick while full, and with no pop in the same cycle:
  - Byte is dropped; FIFO contents are unchanged.
  - rx_overrun <= 1 on the next edge.
- FIFO read: rd_uart while not empty increments rd_ptr and decrements count. rx_data always shows mem[rd_ptr], combinationally from storage.
- Pop while empty is ignored; pointers and flags are unchanged.
- Simultaneous write and read:
  - Not empty and not full: both occur; count unchanged.
  - Full: both occur; no overrun; count stays full.
  - Empty: write only (no bypass); rx_data shows the new byte on the next cycle.
- Flags:
  - rx_empty = (count==0); rx_full = (count==2**FIFO_W); rx_count = count.
  - Pointers are FIFO_W bits plus a separate count register; no full/empty ambiguity.
- Overrun clear: clr_ovr clears rx_overrun on the next edge. If a new overrun occurs in the same cycle as clr_ovr, set wins and the flag stays 1.
- Latency: rx_done_tick at edge N makes the byte visible on rx_data, with rx_empty low, after edge N.
- Reset mid-frame: all state clears immediately; any partially elapsed tick count is lost. The receiver is reset by the same signal.

Decomposition:
- Package uart_pkg:
  - Default constants for DBIT=8 and SB_TICK=16.
  - Helper constant DVSR_115200_100MHZ = 53.
  - FIFO-depth localparam function.
- One sub-module: uart_rx_fifo.
  - Parameters DBIT, FIFO_W.
  - Ports: wr, w_data, rd, r_data, empty, full, count, plus an overrun-attempt output.
- The baud counter and overrun flag stay in uart_rx_ctrl.

Test Plan:
- Baud tick: dvsr=3, then dvsr=0 -> with dvsr=3, s_tick is a 1-cycle pulse every 4 clks (first at cycle 3 after reset release); after switching to dvsr=0, s_tick is high every cycle.
- Divisor shrink: dvsr=100, wait until cnt=50, set dvsr=10 -> s_tick on the next cycle, then every 11 clks.
- Fill and drain: pulse rx_done_tick with bytes 0x11, 0x22, 0x33, 0x44 -> rx_count=4, rx_full=1. Four pops yield 0x11, 0x22, 0x33, 0x44 in order, then rx_empty=1.
- Overrun: full FIFO plus rx_done_tick with 0x55 -> rx_overrun=1 and contents unchanged. clr_ovr clears the flag. clr_ovr in the same cycle as a further drop -> flag stays 1.
- Simultaneous events:
  - Full FIFO, rd_uart and rx_done_tick(0x66) together -> no overrun, count stays 4, 0x66 is last out.
  - Empty FIFO, rd_uart and rx_done_tick(0x77) together -> count=1, rx_data=0x77.
- Async reset: with 2 entries and rx_overrun=1, pulse reset_n low between clk edges -> rx_empty=1, rx_count=0, rx_overrun=0 immediately, without waiting for a clock edge.
